order_dispatch_ctrl: RTL and testbench

Sequencing controller between the inbound order-message FIFO and the bid/ask order-book engines. Pops one 320-bit message at a time, decodes the side byte, waits until the addressed engine reports free, then issues a single-cycle valid strobe with the held message. Unknown side codes are discarded and counted. Per-side dispatch counters are kept, and an optional stall watchdog is provided. Sits directly in front of the two order-book engine instances in the full order-book top.

---
 rtl/order_dispatch_ctrl.sv | 151 +++++++++++++++
 tb/tb_order_dispatch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_dispatch_ctrl.sv
// Order dispatch controller: pops messages from the inbound FIFO and routes each to the bid or ask engine by side code.
// Optional stall watchdog is enabled by defining DISPATCH_TIMEOUT_EN.
module order_dispatch_ctrl #(
    parameter int          MSG_W          = 320,
    parameter int          SIDE_LSB       = 144,
    parameter logic [7:0]  BID_CODE       = 8'h42,
    parameter logic [7:0]  ASK_CODE       = 8'h44,
    parameter int          CNT_W          = 16,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [MSG_W-1:0] fifo_dout,
    input  logic             bid_free,
    input  logic             ask_free,
    output logic [MSG_W-1:0] msg_out,
    output logic             bid_valid,
    output logic             ask_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bid_count,
    output logic [CNT_W-1:0] ask_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             stall_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_DISPATCH,
        S_ISSUE,
        S_HOLD
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   msg_q;
    logic               rd_en_q, bid_valid_q, ask_valid_q, busy_q;
    logic [CNT_W-1:0]   bid_cnt_q, ask_cnt_q, drop_cnt_q;
    logic [7:0]         side;
    logic               is_bid, is_ask, drop_inc;

    assign side   = msg_q[SIDE_LSB +: 8];
    assign is_bid = (side == BID_CODE);
    assign is_ask = (side == ASK_CODE);

`ifdef DISPATCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              stall_err_q, stall_set;
`endif

    always_comb begin
        state_d  = state_q;
        drop_inc = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        wait_d    = wait_q;
        stall_set = 1'b0;
`endif
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_READ;
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_DISPATCH;
`ifdef DISPATCH_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            S_DISPATCH: begin
                // Only the engine addressed by the side code is consulted.
                if ((is_bid && bid_free) || (is_ask && ask_free)) begin
                    state_d = S_ISSUE;
                end else if (!is_bid && !is_ask) begin
                    drop_inc = 1'b1;
                    state_d  = S_HOLD;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    stall_set = 1'b1;
                    drop_inc  = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  state_d = fifo_empty ? S_IDLE : S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            msg_q       <= '0;
            rd_en_q     <= 1'b0;
            bid_valid_q <= 1'b0;
            ask_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            bid_cnt_q   <= '0;
            ask_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= (state_d == S_READ);
            busy_q      <= (state_d != S_IDLE);
            bid_valid_q <= (state_d == S_ISSUE) && is_bid;
            ask_valid_q <= (state_d == S_ISSUE) && is_ask;
            if (state_q == S_LATCH) msg_q <= fifo_dout;
            if (bid_valid_q) bid_cnt_q <= sat_inc(bid_cnt_q);
            if (ask_valid_q) ask_cnt_q <= sat_inc(ask_cnt_q);
            if (drop_inc)    drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_q      <= '0;
            stall_err_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            if (stall_set) stall_err_q <= 1'b1;
        end
    end
    assign stall_err = stall_err_q;
`else
    assign stall_err = 1'b0;
`endif

    assign fifo_rd_en = rd_en_q;
    assign msg_out    = msg_q;
    assign bid_valid  = bid_valid_q;
    assign ask_valid  = ask_valid_q;
    assign busy       = busy_q;
    assign bid_count  = bid_cnt_q;
    assign ask_count  = ask_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_order_dispatch_ctrl.sv
// Directed bench for order_dispatch_ctrl; timeout scenario runs when DISPATCH_TIMEOUT_EN is defined.
module tb_order_dispatch_ctrl;

    localparam int MSG_W    = 320;
    localparam int SIDE_LSB = 144;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [MSG_W-1:0] fifo_dout = '0;
    logic             bid_free, ask_free;
    logic [MSG_W-1:0] msg_out;
    logic             bid_valid, ask_valid, busy, stall_err;
    logic [CNT_W-1:0] bid_count, ask_count, drop_count;

    int tests_run = 0;
    int fails     = 0;

    logic [MSG_W-1:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;

    order_dispatch_ctrl #(
        .MSG_W(MSG_W), .SIDE_LSB(SIDE_LSB), .BID_CODE(8'h42), .ASK_CODE(8'h44),
        .CNT_W(CNT_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .bid_free(bid_free), .ask_free(ask_free), .msg_out(msg_out),
        .bid_valid(bid_valid), .ask_valid(ask_valid), .busy(busy), .bid_count(bid_count),
        .ask_count(ask_count), .drop_count(drop_count), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on fifo_dout the cycle after the pop request.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    function automatic logic [MSG_W-1:0] mk(input logic [7:0] side, input logic [31:0] tag);
        logic [MSG_W-1:0] m;
        m = {10{tag}};
        m[SIDE_LSB +: 8] = side;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [MSG_W-1:0] m);
        mem[wr_ptr % 16] = m;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        bid_free = 1'b1;
        ask_free = 1'b1;
        #2;
        tests_run++;
        if ({fifo_rd_en, bid_valid, ask_valid, busy, stall_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 00000", {fifo_rd_en, bid_valid, ask_valid, busy, stall_err});
        end
        tests_run++;
        if ((msg_out !== '0) || ({bid_count, ask_count, drop_count} !== '0)) begin
            fails++;
            $display("FAIL reset_data: msg_out=%0h counts=%0d/%0d/%0d required all 0", msg_out, bid_count, ask_count, drop_count);
        end
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_bid_single();
        logic [MSG_W-1:0] m;
        m = mk(8'h42, 32'hB1D0_0001);
        push(m);
        for (int c = 0; c <= 6; c++) begin
            tests_run++;
            if (fifo_rd_en !== (c == 1)) begin
                fails++;
                $display("FAIL bid_rd_en c%0d: got %b required %b", c, fifo_rd_en, (c == 1));
            end
            tests_run++;
            if ({bid_valid, ask_valid} !== {(c == 4), 1'b0}) begin
                fails++;
                $display("FAIL bid_valid c%0d: got bid=%b ask=%b required bid=%b ask=0", c, bid_valid, ask_valid, (c == 4));
            end
            tick();
        end
        tests_run++;
        if (msg_out !== m) begin
            fails++;
            $display("FAIL bid_msg: got %0h required %0h", msg_out, m);
        end
        tests_run++;
        if (bid_count !== 16'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bid_count: got count=%0d busy=%b required count=1 busy=0", bid_count, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [MSG_W-1:0] m3;
        m3 = mk(8'h44, 32'hA5C0_0003);
        push(mk(8'h44, 32'hA5C0_0001));
        push(mk(8'h44, 32'hA5C0_0002));
        push(m3);
        for (int c = 0; c <= 16; c++) begin
            tests_run++;
            if ({ask_valid, bid_valid} !== {(c == 4 || c == 9 || c == 14), 1'b0}) begin
                fails++;
                $display("FAIL b2b_valid c%0d: got ask=%b bid=%b required ask=%b bid=0", c, ask_valid, bid_valid, (c == 4 || c == 9 || c == 14));
            end
            if (c == 14) begin
                tests_run++;
                if (msg_out !== m3) begin
                    fails++;
                    $display("FAIL b2b_msg3: got %0h required %0h", msg_out, m3);
                end
            end
            tick();
        end
        tests_run++;
        if (ask_count !== 16'd3 || bid_count !== 16'd1) begin
            fails++;
            $display("FAIL b2b_counts: got ask=%0d bid=%0d required ask=3 bid=1", ask_count, bid_count);
        end
    endtask

    task automatic test_drop();
        push(mk(8'h41, 32'hDEAD_0001));
        for (int c = 0; c <= 6; c++) begin
            tests_run++;
            if ({bid_valid, ask_valid} !== 2'b00) begin
                fails++;
                $display("FAIL drop_valid c%0d: got bid=%b ask=%b required 0", c, bid_valid, ask_valid);
            end
            if (c == 4 || c == 5) begin
                tests_run++;
                if (busy !== (c == 4)) begin
                    fails++;
                    $display("FAIL drop_busy c%0d: got %b required %b", c, busy, (c == 4));
                end
            end
            tick();
        end
        tests_run++;
        if (drop_count !== 16'd1) begin
            fails++;
            $display("FAIL drop_count: got %0d required 1", drop_count);
        end
    endtask

    task automatic test_not_free();
        bid_free = 1'b0;
        push(mk(8'h42, 32'hB1D0_0002));
        for (int c = 0; c <= 13; c++) begin
            if (c == 10) bid_free = 1'b1;
            ask_free = c[0];
            #1;
            tests_run++;
            if ({bid_valid, ask_valid} !== {(c == 11), 1'b0}) begin
                fails++;
                $display("FAIL notfree_valid c%0d: got bid=%b ask=%b required bid=%b ask=0", c, bid_valid, ask_valid, (c == 11));
            end
            tick();
        end
        ask_free = 1'b1;
        tests_run++;
        if (bid_count !== 16'd2 || busy !== 1'b0 || stall_err !== 1'b0) begin
            fails++;
            $display("FAIL notfree_end: got bid=%0d busy=%b stall=%b required bid=2 busy=0 stall=0", bid_count, busy, stall_err);
        end
    endtask

`ifdef DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        ask_free = 1'b0;
        push(mk(8'h44, 32'h7100_0001));
        push(mk(8'h44, 32'h7100_0002));
        for (int c = 0; c <= 25; c++) begin
            if (c == 20) ask_free = 1'b1;
            #1;
            if (c == 18 || c == 19) begin
                tests_run++;
                if (stall_err !== (c == 19)) begin
                    fails++;
                    $display("FAIL timeout_stall c%0d: got %b required %b", c, stall_err, (c == 19));
                end
            end
            tests_run++;
            if ({ask_valid, bid_valid} !== {(c == 23), 1'b0}) begin
                fails++;
                $display("FAIL timeout_valid c%0d: got ask=%b bid=%b required ask=%b bid=0", c, ask_valid, bid_valid, (c == 23));
            end
            tick();
        end
        tests_run++;
        if (drop_count !== 16'd2 || ask_count !== 16'd4 || stall_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_counts: got drop=%0d ask=%0d stall=%b required drop=2 ask=4 stall=1", drop_count, ask_count, stall_err);
        end
    endtask
`endif

    task automatic test_reset_in_dispatch();
        bid_free = 1'b0;
        push(mk(8'h42, 32'hB1D0_0003));
        for (int c = 0; c < 4; c++) tick();
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({fifo_rd_en, bid_valid, ask_valid, busy, stall_err} !== 5'b0 || msg_out !== '0) begin
            fails++;
            $display("FAIL rst_async_ctrl: got %b msg=%0h required 00000 msg=0", {fifo_rd_en, bid_valid, ask_valid, busy, stall_err}, msg_out);
        end
        tests_run++;
        if ({bid_count, ask_count, drop_count} !== '0) begin
            fails++;
            $display("FAIL rst_async_counts: got %0d/%0d/%0d required 0/0/0", bid_count, ask_count, drop_count);
        end
        tick();
        tick();
        resetn   = 1'b1;
        bid_free = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++;
            if ({bid_valid, ask_valid, busy} !== 3'b000) begin
                fails++;
                $display("FAIL rst_no_replay c%0d: got bid=%b ask=%b busy=%b required 0", c, bid_valid, ask_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bid_single();
        test_back_to_back();
        test_drop();
        test_not_free();
`ifdef DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_dispatch();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
